// File: rtl/menu_select.sv
// menu_select: start-screen menu FSM (cursor, editable values, start handshake) plus highlight compositor and palette.
module menu_select #(
  parameter int N_ITEMS      = 4,
  parameter int VAL_W        = 7,
  parameter int VAL_MIN      = 1,
  parameter int VAL_MAX      = 99,
  parameter int VAL_STEP     = 1,
  parameter int VAL_INIT     = 30,
  parameter int LAYERS       = 8,
  parameter int ROW_Y0       = 180,
  parameter int ROW_H        = 32,
  parameter int BLINK_CYCLES = 12_500_000,
  localparam int SW = N_ITEMS > 2 ? $clog2(N_ITEMS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [2:0]               key_code,
  input  logic                     start_ack,
  input  logic                     valid,
  input  logic [9:0]               vgax,
  input  logic [9:0]               vgay,
  input  logic [3*LAYERS-1:0]      layer_ids,
  output logic [SW-1:0]            sel_idx,
  output logic                     editing,
  output logic [VAL_W*N_ITEMS-1:0] vals,
  output logic [VAL_W*N_ITEMS-1:0] disp_vals,
  output logic                     start_req,
  output logic [11:0]              pixel
);
  localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(N_ITEMS - 1);
  localparam logic [BW-1:0] CNT_END = BW'(BLINK_CYCLES - 1);
  localparam logic [VAL_W:0] MIN_W = (VAL_W+1)'(VAL_MIN);
  localparam logic [VAL_W:0] MAX_W = (VAL_W+1)'(VAL_MAX);
  localparam logic [VAL_W:0] STEP_W = (VAL_W+1)'(VAL_STEP);
  typedef enum logic [1:0] {NAV, EDIT, LOCK} state_t;
  state_t state;
  logic [SW-1:0] sel;
  logic [N_ITEMS-1:0][VAL_W-1:0] val_r, disp;
  logic [VAL_W-1:0] shadow;
  logic [VAL_W:0] inc, dec;
  logic [BW-1:0] cnt;
  logic phase, cnt_wrap, hl_row, hl_on;
  logic [15:0] top;
  logic [2:0] id, id_hl;
  logic [11:0] rgb;
  logic unused_vgax;
  assign unused_vgax = ^vgax;
  assign sel_idx = sel;
  assign editing = state == EDIT;
  assign vals = val_r;
  assign disp_vals = disp;
  assign inc = {1'b0, shadow} + STEP_W;
  assign dec = {1'b0, shadow} - STEP_W;
  assign cnt_wrap = cnt == CNT_END;
  assign top = 16'(ROW_Y0) + 16'(sel) * 16'(ROW_H);
  assign hl_row = {6'd0, vgay} >= top && {6'd0, vgay} < top + 16'(ROW_H);
  assign hl_on = hl_row && (state == NAV || (state == EDIT && !phase));
  assign id_hl = (id == 3'd0 && hl_on) ? 3'd5 : id;
  always_comb begin
    disp = val_r;
    if (state == EDIT) disp[sel] = shadow;
  end
  always_comb begin
    id = 3'd0;
    for (int k = 0; k < LAYERS; k++)
      if (layer_ids[3*k +: 3] > id) id = layer_ids[3*k +: 3];
  end
  always_comb begin
    case (id_hl)
      3'd0:    rgb = 12'hFFF;
      3'd1:    rgb = 12'h0FF;
      3'd2:    rgb = 12'hF00;
      3'd3:    rgb = 12'h0F0;
      3'd4:    rgb = 12'h000;
      3'd5:    rgb = 12'hFF0;
      default: rgb = 12'h00F;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NAV;
      sel <= '0;
      for (int k = 0; k < N_ITEMS; k++) val_r[k] <= VAL_W'(VAL_INIT);
      shadow <= VAL_W'(VAL_INIT);
      start_req <= 1'b0;
      cnt <= '0;
      phase <= 1'b0;
      pixel <= 12'h000;
    end else begin
      pixel <= valid ? rgb : 12'h000;
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      phase <= phase ^ cnt_wrap;
      if (state == LOCK) begin
        if (start_ack) begin
          state <= NAV;
          start_req <= 1'b0;
          sel <= '0;
        end
      end else if (key_valid && state == NAV) begin
        case (key_code)
          3'd0: sel <= sel == '0 ? LAST : sel - 1'b1;
          3'd1: sel <= sel == LAST ? '0 : sel + 1'b1;
          3'd4: if (sel == LAST) begin
            start_req <= 1'b1;
            state <= LOCK;
          end else begin
            shadow <= val_r[sel];
            state <= EDIT;
            cnt <= '0;
            phase <= 1'b0;
          end
          default: ;
        endcase
      end else if (key_valid) begin
        case (key_code)
          3'd2: shadow <= (dec[VAL_W] || dec < MIN_W) ? VAL_W'(VAL_MIN) : dec[VAL_W-1:0];
          3'd3: shadow <= inc > MAX_W ? VAL_W'(VAL_MAX) : inc[VAL_W-1:0];
          3'd4: begin
            val_r[sel] <= shadow;
            state <= NAV;
          end
          3'd5: state <= NAV;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_menu_select.sv
// tb_menu_select: directed key/pixel sequence with hand-computed expectations.
module tb_menu_select;
  logic clk = 0, rst = 1, key_valid = 0, start_ack = 0, valid = 0;
  logic [2:0] key_code = 0;
  logic [9:0] vgax = 0, vgay = 0;
  logic [23:0] layer_ids = 0;
  logic [1:0] sel_idx;
  logic editing, start_req;
  logic [27:0] vals, disp_vals;
  logic [11:0] pixel;
  int n_cmp = 0, n_err = 0;

  menu_select #(.BLINK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .start_ack(start_ack), .valid(valid), .vgax(vgax), .vgay(vgay),
    .layer_ids(layer_ids), .sel_idx(sel_idx), .editing(editing), .vals(vals),
    .disp_vals(disp_vals), .start_req(start_req), .pixel(pixel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic key(input logic [2:0] c);
    key_code = c;
    key_valid = 1;
    tick();
    key_valid = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    tick();
    tick();
    check("rst_sel", 32'(sel_idx), 0);
    check("rst_edit", 32'(editing), 0);
    check("rst_vals", 32'(vals), {4{7'd30}});
    check("rst_req", 32'(start_req), 0);
    check("rst_pix", 32'(pixel), 0);
    rst = 0;
    key(1); check("down1", 32'(sel_idx), 1);
    key(1); check("down2", 32'(sel_idx), 2);
    key(1); check("down3", 32'(sel_idx), 3);
    key(1); check("down_wrap", 32'(sel_idx), 0);
    key(0); check("up_wrap", 32'(sel_idx), 3);
    key(1); check("back0", 32'(sel_idx), 0);
    key(4); check("enter_edit", 32'(editing), 1);
    key(3); key(3); key(3);
    check("disp0_33", 32'(disp_vals[6:0]), 33);
    check("vals0_30", 32'(vals[6:0]), 30);
    key(1); check("cursor_frozen", 32'(sel_idx), 0);
    key(4);
    check("commit33", 32'(vals[6:0]), 33);
    check("edit_off", 32'(editing), 0);
    key(4);
    for (int i = 0; i < 65; i++) key(3);
    check("disp0_98", 32'(disp_vals[6:0]), 98);
    key(3); key(3); key(3);
    check("sat_max", 32'(disp_vals[6:0]), 99);
    key(4); check("commit99", 32'(vals[6:0]), 99);
    key(1); key(4);
    for (int i = 0; i < 28; i++) key(2);
    key(4); check("vals1_2", 32'(vals[13:7]), 2);
    key(4);
    for (int i = 0; i < 5; i++) key(2);
    check("sat_min", 32'(disp_vals[13:7]), 1);
    key(5);
    check("esc_vals1", 32'(vals[13:7]), 2);
    check("esc_disp1", 32'(disp_vals[13:7]), 2);
    check("esc_edit", 32'(editing), 0);
    key(1); key(1); key(4);
    check("start_req", 32'(start_req), 1);
    check("lock_edit", 32'(editing), 0);
    key(0); check("lock_up", 32'(sel_idx), 3);
    key(4); check("lock_enter", 32'(start_req), 1);
    start_ack = 1;
    key(1);
    start_ack = 0;
    check("ack_req", 32'(start_req), 0);
    check("ack_sel", 32'(sel_idx), 0);
    key(1); check("nav_after_ack", 32'(sel_idx), 1);
    valid = 1;
    vgay = 212;
    tick(); check("pix_hl_row1", 32'(pixel), 12'hFF0);
    key(0); tick(); check("pix_row0_off", 32'(pixel), 12'hFFF);
    layer_ids = 24'h000400;
    tick(); check("pix_layer2", 32'(pixel), 12'hF00);
    layer_ids = 24'h003001;
    tick(); check("pix_max3", 32'(pixel), 12'h0F0);
    layer_ids = 0;
    valid = 0;
    tick(); check("pix_invalid", 32'(pixel), 12'h000);
    valid = 1;
    vgay = 190;
    key(4);
    for (int i = 0; i < 4; i++) begin
      tick(); check("blink_on", 32'(pixel), 12'hFF0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); check("blink_off", 32'(pixel), 12'hFFF);
    end
    check("still_edit", 32'(editing), 1);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_edit", 32'(editing), 0);
    check("mid_rst_vals", 32'(vals), {4{7'd30}});
    check("mid_rst_pix", 32'(pixel), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/menu_select.md
# menu_select

Parametrised menu controller and compositor for the TypeRacer start screen. Holds N_ITEMS settings (cursor, per-item values, edit/commit/cancel FSM) driven by decoded key events, and issues a start request on the last item. It also merges up to LAYERS glyph-renderer pixel ids, adds a blinking row highlight for the cursor, and registers the 12-bit VGA colour.

## Interface
Parameters:
- N_ITEMS, 4, number of menu rows (≥2); row N_ITEMS-1 is the START row and carries no value.
- VAL_W, 7, bit width of each item value.
- VAL_MIN, 1, lowest legal value.
- VAL_MAX, 99, highest legal value (VAL_MIN < VAL_MAX < 2^VAL_W).
- VAL_STEP, 1, increment/decrement step.
- VAL_INIT, 30, reset value of every item.
- LAYERS, 8, number of 3-bit pixel-id inputs merged.
- ROW_Y0, 180, vgay of row 0 top line.
- ROW_H, 32, row height in lines.
- BLINK_CYCLES, 12_500_000, clk cycles per blink phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle key event strobe.
- key_code  in  3  0 up, 1 down, 2 left/dec, 3 right/inc, 4 enter, 5 escape; 6–7 ignored.
- start_ack  in  1  consumer accepted start.
- valid  in  1  VGA active-area flag.
- vgax, vgay  in  10 each  current VGA coordinate.
- layer_ids  in  3*LAYERS  packed glyph pixel ids; layer k in bits [3k+2:3k].
- sel_idx  out  max(1,clog2(N_ITEMS))  cursor row.
- editing  out  1  high in EDIT.
- vals  out  VAL_W*N_ITEMS  committed values; item k in bits [VAL_W*k+VAL_W-1:VAL_W*k].
- disp_vals  out  VAL_W*N_ITEMS  like vals, but the selected item shows the shadow value while editing.
- start_req  out  1  level, high until start_ack.
- pixel  out  12  registered RGB444.

## Operation
FSM states: NAV, EDIT, LOCK.
- NAV:
  - up: sel_idx-1, wrapping 0→N_ITEMS-1.
  - down: sel_idx+1, wrapping N_ITEMS-1→0.
  - enter on a value row: copy the committed value to the shadow and go to EDIT.
  - enter on the START row: set start_req and go to LOCK.
  - left, right, escape, codes 6–7: no effect.
- EDIT:
  - right: shadow = min(shadow+VAL_STEP, VAL_MAX), saturating; compute in VAL_W+1 bits, no wrap.
  - left: shadow = max(shadow−VAL_STEP, VAL_MIN), saturating; compute in VAL_W+1 bits, no wrap.
  - enter: commit shadow to vals[sel] and go to NAV.
  - escape: discard shadow and go to NAV.
  - up/down: ignored; the cursor is frozen.
- LOCK:
  - All keys are ignored.
  - start_ack: clear start_req and go to NAV with sel_idx = 0.
- start_ack outside LOCK: ignored.
- Blink:
  - Counter 0..BLINK_CYCLES-1; the blink phase toggles on wrap.
  - The counter and phase clear on every entry to EDIT, so the highlight starts visible.
- Highlight row: vgay in [ROW_Y0+sel_idx*ROW_H, ROW_Y0+(sel_idx+1)*ROW_H).
  - NAV: always on.
  - EDIT: on when the blink phase is 0.
  - LOCK: off.
- Compositing:
  - id = unsigned max of all layers.
  - If id==0 inside an active highlight row, id becomes 5.
- Palette: 0 FFF, 1 0FF, 2 F00, 3 0F0, 4 000, 5 FF0; 6–7 00F (error).
- valid low: pixel = 000.

## Timing
- Key path:
  - The event is sampled on the clk edge where key_valid=1.
  - sel_idx, editing, shadow, vals and start_req reflect it after that same edge, i.e. 1-cycle latency.
  - Back-to-back key events on consecutive cycles are each processed.
- start_ack and key_valid in the same cycle in LOCK: the ack is taken and the key is dropped.
- Pixel path:
  - 1-cycle latency: pixel at edge n+1 is a function of valid, vgax, vgay, layer_ids and the sel/FSM/blink state at edge n.
  - No internal clock divider; upstream supplies coordinates at clk rate or holds them.
- Reset values, taking effect on the first rising clk with rst=1, including mid-edit or in LOCK:
  - state NAV, sel_idx 0, editing 0;
  - all vals and disp_vals VAL_INIT, shadow VAL_INIT;
  - start_req 0, blink counter and phase 0, pixel 000.

## Test plan
- Reset, then four down keys with N_ITEMS=4 → sel_idx 1,2,3,0; one up from 0 → 3.
- sel 0, enter, right ×3 with VAL_INIT=30 → disp_vals item0 = 33 while vals item0 stays 30; enter → vals item0 = 33 and editing=0.
- Shadow 98, right ×3 with VAL_MAX=99 → 99; min test: item 1 at 2, left ×5 → VAL_MIN=1; then escape → vals item1 unchanged.
- sel 3 (START), enter → start_req=1; up/enter ignored while it is held; start_ack → start_req=0 next edge, sel_idx=0.
- All layers 0, valid=1, vgay=ROW_Y0+ROW_H, sel_idx=1, NAV → pixel FF0; same point with sel_idx=0 → FFF; one layer =2 → F00; valid=0 → 000.
- BLINK_CYCLES=4 in EDIT on row 0 → highlight FF0 for 4 cycles, then FFF for 4; rst asserted mid-EDIT → editing=0, vals=VAL_INIT, pixel 000 after one edge.
